// File: rtl/rx_byte_fifo_if.sv
// Handshake bundle between the UART receiver/consumer and rx_byte_fifo.
// Optional ovfCount signal present when RX_FIFO_OVF_COUNT_EN is defined.
interface rx_byte_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 3
);
    logic [DATA_WIDTH-1:0] wrData;
    logic                  wrDone;
    logic                  rdReq;
    logic                  ovfClr;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  rdValid;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
`ifdef RX_FIFO_OVF_COUNT_EN
    logic [7:0]            ovfCount;
`endif

    modport master (
        output wrData, wrDone, rdReq, ovfClr,
`ifdef RX_FIFO_OVF_COUNT_EN
        input  ovfCount,
`endif
        input  rdData, rdValid, full, empty, count, overflow
    );

    modport slave (
        input  wrData, wrDone, rdReq, ovfClr,
`ifdef RX_FIFO_OVF_COUNT_EN
        output ovfCount,
`endif
        output rdData, rdValid, full, empty, count, overflow
    );
endinterface

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO with edge-detected write strobe, registered pop and sticky overflow.
// Define RX_FIFO_OVF_COUNT_EN to add a saturating dropped-byte counter (ovfCount).
module rx_byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input logic           clk,
    input logic           rst,
    rx_byte_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  wr_done_q;
    logic                  armed_q;

    logic full, empty;
    logic wr_stb, wr_acc, rd_acc, drop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // armed_q masks the first edge after reset so a level held through reset never writes.
    assign wr_stb = bus.wrDone & ~wr_done_q & armed_q;
    assign rd_acc = bus.rdReq & ~empty;
    assign wr_acc = wr_stb & (~full | rd_acc);
    assign drop   = wr_stb & full & ~rd_acc;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_done_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            wr_done_q  <= bus.wrDone;
            armed_q    <= 1'b1;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem[rd_ptr_q];
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovfClr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.wrData;
        end
    end

`ifdef RX_FIFO_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q;

    // A drop coinciding with a clear is still counted, matching the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (bus.ovfClr) begin
            ovf_cnt_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && ovf_cnt_q != 8'hff) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign bus.ovfCount = ovf_cnt_q;
`endif

    assign bus.rdData   = rd_data_q;
    assign bus.rdValid  = rd_valid_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed self-checking bench for rx_byte_fifo; covers ovfCount when RX_FIFO_OVF_COUNT_EN is set.
module tb_rx_byte_fifo;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rx_byte_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) bus ();

    rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wrData = d;
        bus.wrDone = 1'b1;
        step();
        bus.wrDone = 1'b0;
        step();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        bus.rdReq = 1'b1;
        step();
        bus.rdReq = 1'b0;
        check({tag, "_valid"}, 32'(bus.rdValid), 32'd1);
        check({tag, "_data"}, 32'(bus.rdData), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wrData = '0;
        bus.wrDone = 1'b0;
        bus.rdReq  = 1'b0;
        bus.ovfClr = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_valid", 32'(bus.rdValid), 32'd0);
        check("rst_data", 32'(bus.rdData), 32'd0);
        rst = 1'b0;
        step();

        // Three pulsed writes, three pops in order.
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("t1_count", 32'(bus.count), 32'd3);
        pop_check("t1_pop0", 8'h41);
        step();
        check("t1_valid_pulse", 32'(bus.rdValid), 32'd0);
        pop_check("t1_pop1", 8'h42);
        pop_check("t1_pop2", 8'h43);
        check("t1_empty", 32'(bus.empty), 32'd1);

        // Held wrDone writes once.
        bus.wrData = 8'h55;
        bus.wrDone = 1'b1;
        repeat (10) step();
        bus.wrDone = 1'b0;
        step();
        check("t2_count", 32'(bus.count), 32'd1);
        pop_check("t2_pop", 8'h55);

        // Fill, then overflow.
        for (int i = 0; i < 8; i++) push(8'(i));
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_count8", 32'(bus.count), 32'd8);
        check("t3_ovf0", 32'(bus.overflow), 32'd0);
        push(8'h08);
        check("t3_count_drop", 32'(bus.count), 32'd8);
        check("t3_ovf1", 32'(bus.overflow), 32'd1);
`ifdef RX_FIFO_OVF_COUNT_EN
        check("t3_ovfcnt", 32'(bus.ovfCount), 32'd1);
`endif
        bus.ovfClr = 1'b1;
        step();
        bus.ovfClr = 1'b0;
        check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
        bus.wrData = 8'h99;
        bus.wrDone = 1'b1;
        bus.ovfClr = 1'b1;
        step();
        bus.wrDone = 1'b0;
        bus.ovfClr = 1'b0;
        check("t3_ovf_set_prio", 32'(bus.overflow), 32'd1);
        step();
        bus.ovfClr = 1'b1;
        step();
        bus.ovfClr = 1'b0;
        check("t3_ovf_clr2", 32'(bus.overflow), 32'd0);

        // Simultaneous write and pop at full.
        bus.wrData = 8'hAA;
        bus.wrDone = 1'b1;
        bus.rdReq  = 1'b1;
        step();
        bus.wrDone = 1'b0;
        bus.rdReq  = 1'b0;
        check("t4_valid", 32'(bus.rdValid), 32'd1);
        check("t4_data", 32'(bus.rdData), 32'h00);
        check("t4_count", 32'(bus.count), 32'd8);
        check("t4_ovf", 32'(bus.overflow), 32'd0);
        step();
        for (int i = 1; i < 8; i++) pop_check("t4_pop", 8'(i));
        pop_check("t4_pop_aa", 8'hAA);
        check("t4_empty", 32'(bus.empty), 32'd1);

        // Pop while empty is ignored.
        bus.rdReq = 1'b1;
        step();
        bus.rdReq = 1'b0;
        check("e_valid", 32'(bus.rdValid), 32'd0);
        check("e_data_hold", 32'(bus.rdData), 32'hAA);
        check("e_count", 32'(bus.count), 32'd0);

        // Write and pop together while empty: no fall-through.
        bus.wrData = 8'h10;
        bus.wrDone = 1'b1;
        bus.rdReq  = 1'b1;
        step();
        bus.wrDone = 1'b0;
        bus.rdReq  = 1'b0;
        check("t5_valid", 32'(bus.rdValid), 32'd0);
        check("t5_count", 32'(bus.count), 32'd1);
        step();
        pop_check("t5_pop", 8'h10);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        check("t6_count5", 32'(bus.count), 32'd5);
        bus.rdReq = 1'b1;
        step();
        rst = 1'b1;
        #2;
        check("t6_count", 32'(bus.count), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_full", 32'(bus.full), 32'd0);
        check("t6_valid", 32'(bus.rdValid), 32'd0);
        check("t6_ovf", 32'(bus.overflow), 32'd0);
        check("t6_data", 32'(bus.rdData), 32'd0);
        bus.rdReq = 1'b0;
        #1;
        rst = 1'b0;
        step();

        // wrDone held through reset must not write after release.
        bus.wrDone = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("t7_no_write", 32'(bus.count), 32'd0);
        bus.wrData = 8'h77;
        bus.wrDone = 1'b0;
        step();
        bus.wrDone = 1'b1;
        step();
        bus.wrDone = 1'b0;
        check("t7_fresh_edge", 32'(bus.count), 32'd1);
        step();
        pop_check("t7_pop", 8'h77);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each stored byte.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3: log2 of entry count (8 entries).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port wrData  input  DATA_WIDTH  received byte from the UART receiver.
REQ-006 SHALL have port wrDone  input  1  receiver done flag; may be a 1-cycle pulse or a held level.
REQ-007 SHALL have port rdReq  input  1  consumer pop request.
REQ-008 SHALL have port ovfClr  input  1  clears sticky overflow.
REQ-009 SHALL have port rdData  output  DATA_WIDTH  registered popped byte.
REQ-010 SHALL have port rdValid  output  1  1-cycle pulse; rdData holds a newly popped byte.
REQ-011 SHALL have port full  output  1  count equals 2^DEPTH_LOG2.
REQ-012 SHALL have port empty  output  1  count equals 0.
REQ-013 SHALL have port count  output  DEPTH_LOG2+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag; a write was dropped.

Function
REQ-015 SHALL register wrDone and generate a write strobe on its rising edge only, so a held level writes exactly once.
REQ-016 SHALL capture wrData on the write-strobe cycle into mem[wrPtr] when not full, then increment wrPtr modulo 2^DEPTH_LOG2.
REQ-017 SHALL, on rdReq with empty=0, load rdData from mem[rdPtr], increment rdPtr modulo depth, and assert rdValid in the following cycle (1-cycle latency).
REQ-018 SHALL ignore rdReq when empty: rdValid stays 0, rdData and rdPtr unchanged.
REQ-019 SHALL update count by +1 on write-only, -1 on read-only, and keep it unchanged on simultaneous accepted write and read.
REQ-020 SHALL accept both operations on simultaneous write strobe and rdReq when full; count stays at depth and no overflow is raised.
REQ-021 SHALL accept only the write on simultaneous write strobe and rdReq when empty (no fall-through); count goes to 1 and rdValid stays 0.
REQ-022 SHALL drop the byte on a write strobe when full without rdReq, leave mem, pointers and count unchanged, and set overflow.
REQ-023 SHALL clear overflow on ovfClr, with set taking priority when a drop coincides with ovfClr.
REQ-024 SHALL derive full and empty combinationally from count.
REQ-025 SHALL not alter rdData except on an accepted pop.

Reset
REQ-026 SHALL, while rst=1, immediately force wrPtr=0, rdPtr=0, count=0, rdData=0, rdValid=0, overflow=0, and the wrDone edge register to 0; mem contents are not reset.
REQ-027 SHALL discard any in-flight pop or write when reset is asserted mid-operation; after release, empty=1 and full=0.
REQ-028 SHALL not generate a write strobe after reset release if wrDone is already high; a fresh low-to-high transition is required.

Configuration
REQ-029 SHALL, when macro RX_FIFO_OVF_COUNT_EN is defined, add output ovfCount (8 bits) that counts dropped bytes, saturates at 255, and is cleared by rst or ovfClr.
REQ-030 SHALL, when RX_FIFO_OVF_COUNT_EN is undefined, omit the ovfCount port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL pass this test: write 0x41, 0x42, 0x43 via wrDone pulses, then three rdReq -> rdValid pulses carry 0x41, 0x42, 0x43 in order, each one cycle after its rdReq; empty=1 at the end.
REQ-032 SHALL pass this test: hold wrDone high for 10 cycles with wrData=0x55 -> count=1.
REQ-033 SHALL pass this test: write 9 bytes 0x00..0x08 with no reads -> full=1, count=8, overflow=1, ovfCount=1 if enabled; 8 pops return 0x00..0x07.
REQ-034 SHALL pass this test: at full, a write strobe of 0xAA coinciding with rdReq -> oldest byte popped, count=8, overflow=0; 0xAA is popped eighth.
REQ-035 SHALL pass this test: rdReq while empty, simultaneous with a write of 0x10 -> rdValid=0, count=1; the next rdReq yields 0x10.
REQ-036 SHALL pass this test: pulse rst with count=5 and a pending pop -> count=0, empty=1, rdValid=0, overflow=0 immediately, without waiting for a clock edge.
